amx_frame_tx: RTL and testbench

//  Host-side framing transmitter for the AMX byte-stream link. Buffers payload

---
 rtl/amx_frame_pkg.sv | 20 ++
 rtl/amx_frame_tx_if.sv | 27 ++
 rtl/amx_byte_fifo.sv | 41 ++++
 rtl/amx_frame_tx.sv | 147 ++++++++++++++
 tb/tb_amx_frame_tx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amx_frame_pkg.sv
// Shared definitions for the AMX frame transmitter: byte defaults, FSM states
// and the running-checksum helper.
package amx_frame_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] IDLE_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/amx_frame_tx_if.sv
// Payload, command and bus-side signals of the AMX frame transmitter.
// The host side drives through master; the transmitter uses slave.
interface amx_frame_tx_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] cmd_len;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       busy;
  logic       done;
  logic       stall;

  modport master (
    output s_data, s_valid, cmd_len, cmd_valid,
    input  s_ready, cmd_ready, tx_data, tx_strobe, busy, done, stall
  );

  modport slave (
    input  s_data, s_valid, cmd_len, cmd_valid,
    output s_ready, cmd_ready, tx_data, tx_strobe, busy, done, stall
  );

endinterface

// File: rtl/amx_byte_fifo.sv
// Byte FIFO with first-word-fall-through read; the caller guarantees no push
// while full and no pop while empty.
module amx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/amx_frame_tx.sv
// AMX frame transmitter: buffers payload bytes and, per command, emits
// SYNC, LEN, PAYLOAD[0..LEN-1], CHK on a registered byte bus.
//
// state      | meaning
// IDLE       | waiting for a command, cmd_ready high
// SYNC       | SYNC byte on the bus or in the gap after it
// LEN        | LEN byte on the bus, gap after it, or waiting for first payload byte
// PAYLOAD    | payload byte on the bus, gap after it, or waiting for the next one
// CHK        | checksum byte on the bus with done; back to IDLE next cycle
module amx_frame_tx
  import amx_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         GAP        = 0,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter logic [7:0] IDLE_BYTE  = IDLE_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  amx_frame_tx_if.slave bus
);

  localparam int             GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP);

  logic       push, pop, full, empty;
  logic [7:0] fifo_data;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          stall_q, stall_d;

  assign bus.s_ready = !full && !rst;
  assign push        = bus.s_valid && bus.s_ready;

  amx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.s_data),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      data_q   <= IDLE_BYTE;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
    end
  end

  // The state names the byte most recently strobed; the next byte is
  // registered onto the bus once the gap counter has run down to zero.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rem_d    = rem_q;
    len_d    = len_q;
    acc_d    = acc_q;
    data_d   = IDLE_BYTE;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    stall_d  = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          len_d    = bus.cmd_len;
          rem_d    = bus.cmd_len;
          acc_d    = '0;
          gap_d    = GAP_LOAD;
          data_d   = SYNC_BYTE;
          strobe_d = 1'b1;
          state_d  = ST_SYNC;
        end
      end
      ST_CHK: state_d = ST_IDLE;
      default: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else begin
          case (state_q)
            ST_SYNC: begin
              data_d   = len_q;
              acc_d    = chk_update(acc_q, len_q);
              strobe_d = 1'b1;
              gap_d    = GAP_LOAD;
              state_d  = ST_LEN;
            end
            ST_LEN, ST_PAYLOAD: begin
              if (rem_q == 8'd0) begin
                data_d   = acc_q;
                strobe_d = 1'b1;
                done_d   = 1'b1;
                state_d  = ST_CHK;
              end else if (empty) begin
                stall_d = 1'b1;
              end else begin
                pop      = 1'b1;
                data_d   = fifo_data;
                acc_d    = chk_update(acc_q, fifo_data);
                rem_d    = rem_q - 8'd1;
                strobe_d = 1'b1;
                gap_d    = GAP_LOAD;
                state_d  = ST_PAYLOAD;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.tx_data   = data_q;
  assign bus.tx_strobe = strobe_q;
  assign bus.done      = done_q;
  assign bus.stall     = stall_q;

endmodule

// File: tb/tb_amx_frame_tx.sv
// Scoreboard bench for amx_frame_tx: one instance at GAP=0 and one at GAP=2,
// expected frames built from a byte-queue model and checked by monitors.
module tb_amx_frame_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;

  amx_frame_tx_if bus0 ();
  amx_frame_tx_if bus2 ();

  amx_frame_tx #(.FIFO_DEPTH(16), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  amx_frame_tx #(.FIFO_DEPTH(16), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  exp_t       exp0[$];
  exp_t       exp2[$];
  logic [7:0] mq[$];

  int cyc = 0;
  int stall_cnt0 = 0;
  int last0 = -1;
  int last2 = -1;
  bit stalled0 = 0;
  bit prev_done0 = 0;
  bit prev_done2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string nm, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    return e;
  endfunction

  // Monitor for the GAP=0 instance.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last0 = -1;
      stalled0 = 0;
      prev_done0 = 0;
    end else begin
      chk(bus0.cmd_ready == !bus0.busy, "cmd_ready0", bus0.cmd_ready, !bus0.busy);
      if (prev_done0) chk(bus0.busy == 1'b0, "busy_after_chk0", bus0.busy, 0);
      if (bus0.tx_strobe) begin
        exp_t e;
        chk(bus0.busy == 1'b1, "busy_in_frame0", bus0.busy, 1);
        if (exp0.size() == 0) begin
          chk(1'b0, "unexpected_strobe0", bus0.tx_data, -1);
        end else begin
          e = exp0.pop_front();
          chk(bus0.tx_data == e.data, "tx_data0", bus0.tx_data, e.data);
          chk(bus0.done == e.last, "done0", bus0.done, e.last);
        end
        if (last0 >= 0 && !stalled0) chk(cyc - last0 == 1, "spacing0", cyc - last0, 1);
        last0 = bus0.done ? -1 : cyc;
        stalled0 = 0;
      end else begin
        chk(bus0.tx_data == 8'h00, "idle_data0", bus0.tx_data, 0);
        chk(bus0.done == 1'b0, "done_idle0", bus0.done, 0);
      end
      if (bus0.stall) begin
        stall_cnt0++;
        stalled0 = 1;
        chk(bus0.busy == 1'b1, "stall_busy0", bus0.busy, 1);
      end
      prev_done0 = bus0.done;
    end
  end

  // Monitor for the GAP=2 instance.
  always @(negedge clk) begin
    if (rst) begin
      last2 = -1;
      prev_done2 = 0;
    end else begin
      if (prev_done2) chk(bus2.busy == 1'b0, "busy_after_chk2", bus2.busy, 0);
      if (bus2.tx_strobe) begin
        exp_t e;
        if (exp2.size() == 0) begin
          chk(1'b0, "unexpected_strobe2", bus2.tx_data, -1);
        end else begin
          e = exp2.pop_front();
          chk(bus2.tx_data == e.data, "tx_data2", bus2.tx_data, e.data);
          chk(bus2.done == e.last, "done2", bus2.done, e.last);
        end
        if (last2 >= 0) chk(cyc - last2 == 3, "spacing2", cyc - last2, 3);
        last2 = bus2.done ? -1 : cyc;
      end else begin
        chk(bus2.tx_data == 8'h00, "idle_data2", bus2.tx_data, 0);
      end
      chk(bus2.stall == 1'b0, "stall2", bus2.stall, 0);
      prev_done2 = bus2.done;
    end
  end

  task automatic drive_push(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!bus0.s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus0.s_ready) begin
      chk(1'b0, "push_timeout", 0, 1);
    end else begin
      bus0.s_data  = b;
      bus0.s_valid = 1'b1;
      @(posedge clk);
      #1 bus0.s_valid = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive_push(b);
    mq.push_back(b);
  endtask

  task automatic send_cmd(input int len);
    int t = 0;
    logic [7:0] acc;
    logic [7:0] b;
    @(negedge clk);
    while ((!bus0.cmd_ready || mq.size() < len) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus0.cmd_ready || mq.size() < len) begin
      chk(1'b0, "cmd_timeout", mq.size(), len);
      return;
    end
    acc = 8'(len);
    exp0.push_back(mk(8'hA5, 1'b0));
    exp0.push_back(mk(8'(len), 1'b0));
    for (int i = 0; i < len; i++) begin
      b = mq.pop_front();
      acc = acc ^ b;
      exp0.push_back(mk(b, 1'b0));
    end
    exp0.push_back(mk(acc, 1'b1));
    bus0.cmd_len   = 8'(len);
    bus0.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus0.cmd_valid = 1'b0;
    @(negedge clk);
    chk(bus0.tx_strobe && bus0.busy, "sync_latency", {bus0.tx_strobe, bus0.busy}, 3);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp0.size() != 0 || exp2.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(exp0.size() == 0 && exp2.size() == 0, "drain", exp0.size() + exp2.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  int lens[8];
  int total;
  int s0;

  initial begin
    rst = 1'b1;
    bus0.s_data = '0; bus0.s_valid = 1'b0; bus0.cmd_len = '0; bus0.cmd_valid = 1'b0;
    bus2.s_data = '0; bus2.s_valid = 1'b0; bus2.cmd_len = '0; bus2.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus0.tx_data == 8'h00, "rst_tx_data", bus0.tx_data, 0);
    chk(bus0.tx_strobe == 1'b0, "rst_strobe", bus0.tx_strobe, 0);
    chk(bus0.busy == 1'b0, "rst_busy", bus0.busy, 0);
    chk(bus0.s_ready == 1'b0, "rst_s_ready", bus0.s_ready, 0);
    chk(bus0.cmd_ready == 1'b0, "rst_cmd_ready", bus0.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk(bus0.s_ready == 1'b1, "post_rst_s_ready", bus0.s_ready, 1);
    chk(bus0.cmd_ready == 1'b1, "post_rst_cmd_ready", bus0.cmd_ready, 1);

    // Three-byte frame, back to back.
    push_byte(8'h03); push_byte(8'h11); push_byte(8'h22);
    send_cmd(3);
    wait_drain();

    // Empty frame with an empty FIFO: no payload phase, no stall.
    s0 = stall_cnt0;
    send_cmd(0);
    wait_drain();
    chk(stall_cnt0 == s0, "no_stall_len0", stall_cnt0 - s0, 0);

    // Payload starves after the first byte; the second arrives late.
    s0 = stall_cnt0;
    push_byte(8'h7E);
    mq.push_back(8'h81);
    send_cmd(2);
    repeat (5) @(negedge clk);
    drive_push(8'h81);
    wait_drain();
    chk(stall_cnt0 > s0, "stall_seen", stall_cnt0 - s0, 1);

    // GAP=2 instance: fixed frame then a few random short frames.
    for (int f = 0; f < 3; f++) begin
      logic [7:0] acc2;
      logic [7:0] b2;
      int l2;
      l2 = (f == 0) ? 1 : int'($urandom_range(0, 3));
      acc2 = 8'(l2);
      exp2.push_back(mk(8'hA5, 1'b0));
      exp2.push_back(mk(8'(l2), 1'b0));
      for (int i = 0; i < l2; i++) begin
        b2 = (f == 0) ? 8'h55 : 8'($urandom);
        acc2 = acc2 ^ b2;
        exp2.push_back(mk(b2, 1'b0));
        @(negedge clk);
        bus2.s_data = b2; bus2.s_valid = 1'b1;
        @(posedge clk);
        #1 bus2.s_valid = 1'b0;
      end
      exp2.push_back(mk(acc2, 1'b1));
      @(negedge clk);
      bus2.cmd_len = 8'(l2); bus2.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus2.cmd_valid = 1'b0;
      wait_drain();
    end

    // Fill to depth, then a full-length frame with pushes racing the pops.
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    @(negedge clk);
    chk(bus0.s_ready == 1'b0, "full_s_ready", bus0.s_ready, 0);
    fork
      send_cmd(16);
      for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    join
    send_cmd(6);
    wait_drain();

    // Random lengths with concurrent random pushes.
    total = 0;
    for (int i = 0; i < 8; i++) begin
      lens[i] = int'($urandom_range(0, 12));
      total += lens[i];
    end
    fork
      for (int i = 0; i < 8; i++) send_cmd(lens[i]);
      for (int i = 0; i < total; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push_byte(8'($urandom));
      end
    join
    wait_drain();

    // Reset in the middle of a payload, then a fresh frame.
    for (int i = 0; i < 8; i++) push_byte(8'($urandom));
    send_cmd(8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(bus0.tx_strobe == 1'b0, "midrst_strobe", bus0.tx_strobe, 0);
    chk(bus0.tx_data == 8'h00, "midrst_tx_data", bus0.tx_data, 0);
    chk(bus0.busy == 1'b0, "midrst_busy", bus0.busy, 0);
    chk(bus0.done == 1'b0, "midrst_done", bus0.done, 0);
    chk(bus0.stall == 1'b0, "midrst_stall", bus0.stall, 0);
    chk(bus0.s_ready == 1'b0, "midrst_s_ready", bus0.s_ready, 0);
    exp0.delete();
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(bus0.cmd_ready == 1'b1, "after_rst_cmd_ready", bus0.cmd_ready, 1);
    push_byte(8'h9C);
    send_cmd(1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
